fnv1a_octet_hasher: RTL and testbench

- FNV-1a 32-bit hash engine that sits directly downstream of the hasher FSM.
- Absorbs one octet per cycle from the FSM's byte stream, terminated by a last flag.
- After the last octet, emits the 32-bit digest as four octets toward from_hash_fifo.
- Both sides use valid/ready handshakes. Hashing arithmetic is isolated here, so the FSM deals only with FIFO sequencing.

---
 rtl/fnv_pkg.sv | 25 ++
 rtl/fnv1a_step.sv | 19 +
 rtl/fnv1a_octet_hasher.sv | 116 +++++++++++
 tb/tb_fnv1a_octet_hasher.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnv_pkg.sv
// Shared FNV-1a 32-bit constants, FSM state encoding and digest byte selection.
package fnv_pkg;

    localparam logic [31:0] FNV32_OFFSET_BASIS = 32'h811C9DC5;
    localparam logic [31:0] FNV32_PRIME        = 32'h01000193;

    // ABSORB takes message octets, EMIT drives the four digest octets out.
    typedef enum logic {
        ABSORB = 1'b0,
        EMIT   = 1'b1
    } state_t;

    // Returns digest octet number idx (0 = first on the wire).
    // msb_first=1 sends bits [31:24] first, msb_first=0 sends bits [7:0] first.
    function automatic logic [7:0] digest_byte(
        input logic [31:0] h,
        input logic [1:0]  idx,
        input bit          msb_first
    );
        logic [1:0] sel;
        sel = msb_first ? (2'd3 - idx) : idx;
        return h[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fnv1a_step.sv
// One FNV-1a round: xor in an octet, then multiply by the 32-bit FNV prime.
// The prime 0x01000193 = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0, so the multiply
// is a fixed shift-add tree that closes in a single cycle without a DSP.
module fnv1a_step (
    input  logic [31:0] hash_in,
    input  logic [7:0]  octet,
    output logic [31:0] hash_out
);

    logic [31:0] w_x;

    // Xor stage followed by the constant-multiply shift-add, all mod 2^32.
    always_comb begin
        w_x      = hash_in ^ {24'b0, octet};
        hash_out = (w_x << 24) + (w_x << 8) + (w_x << 7)
                 + (w_x << 4)  + (w_x << 1) + w_x;
    end

endmodule

// File: rtl/fnv1a_octet_hasher.sv
// FNV-1a 32-bit octet hasher: absorbs one octet per cycle until in_last, then
// emits the digest as four octets.
//
// Handshakes on both sides: a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds in_data/in_last stable while
// in_valid is high and in_ready is low; this block holds out_data/out_last
// stable while out_valid is high and out_ready is low.
module fnv1a_octet_hasher
    import fnv_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int MSG_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [MSG_CNT_W-1:0] msg_count,
    output logic                 dbg_state
);

    localparam logic [MSG_CNT_W-1:0] CNT_ONE = {{(MSG_CNT_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [31:0]          r_hash;
    logic [1:0]           r_byte_idx;
    logic                 r_started;
    logic [MSG_CNT_W-1:0] r_msg_count;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_out_last;

    logic [31:0]          w_hash_next;
    logic                 w_accept;
    logic [1:0]           w_idx_next;

    fnv1a_step u_step (
        .hash_in  (r_hash),
        .octet    (in_data),
        .hash_out (w_hash_next)
    );

    // Ready only in ABSORB, and never while reset is held low.
    assign in_ready   = reset && (r_state == ABSORB);
    assign w_accept   = in_valid && in_ready;
    assign w_idx_next = r_byte_idx + 2'd1;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_started || (r_state == EMIT);
    assign msg_count  = r_msg_count;
    assign dbg_state  = (r_state == EMIT);

    // Hasher FSM: absorbs octets, then walks the digest out one octet per handshake.
    // Output octets are registered; the next one is preloaded on each handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ABSORB;
            r_hash      <= FNV32_OFFSET_BASIS;
            r_byte_idx  <= 2'd0;
            r_started   <= 1'b0;
            r_msg_count <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ABSORB: begin
                    if (w_accept) begin
                        r_hash    <= w_hash_next;
                        r_started <= 1'b1;
                        if (in_last) begin
                            // Digest is w_hash_next; present its first octet next cycle.
                            r_state     <= EMIT;
                            r_byte_idx  <= 2'd0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= digest_byte(w_hash_next, 2'd0, MSB_FIRST);
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_byte_idx == 2'd3) begin
                            // Final octet taken: rearm for the next message.
                            r_state     <= ABSORB;
                            r_hash      <= FNV32_OFFSET_BASIS;
                            r_byte_idx  <= 2'd0;
                            r_started   <= 1'b0;
                            r_msg_count <= r_msg_count + CNT_ONE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= 8'h00;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_byte_idx <= w_idx_next;
                            r_out_data <= digest_byte(r_hash, w_idx_next, MSB_FIRST);
                            r_out_last <= (w_idx_next == 2'd3);
                        end
                    end
                end
                default: begin
                    r_state <= ABSORB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnv1a_octet_hasher.sv
// Bench for fnv1a_octet_hasher. Two instances share all inputs: dut_a sends the
// digest MSB first with an 8-bit message counter, dut_b sends it LSB first with
// a 2-bit counter so the wrap is reachable quickly.
module tb_fnv1a_octet_hasher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_dbg_state;
    logic [7:0] a_out_data;
    logic [7:0] a_msg_count;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_dbg_state;
    logic [7:0] b_out_data;
    logic [1:0] b_msg_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];
    logic [8:0] ea, eb;
    logic [7:0] msg_buf[16];

    // Clock and reset block
    always #5 clk = ~clk;

    fnv1a_octet_hasher #(.MSB_FIRST(1'b1), .MSG_CNT_W(8)) dut_a (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(out_ready), .busy(a_busy), .msg_count(a_msg_count), .dbg_state(a_dbg_state)
    );

    fnv1a_octet_hasher #(.MSB_FIRST(1'b0), .MSG_CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(out_ready), .busy(b_busy), .msg_count(b_msg_count), .dbg_state(b_dbg_state)
    );

    // Reference FNV-1a over msg_buf[0..len-1], written with a plain multiply.
    function automatic logic [31:0] fnv_model(input int len);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < len; i++) h = (h ^ {24'h0, msg_buf[i]}) * 32'h01000193;
        return h;
    endfunction

    // Scoreboard: queue the four {last,octet} entries each DUT should emit.
    task automatic push_expected(input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            exp_a_q.push_back({(k == 3), d[8*(3-k) +: 8]});
            exp_b_q.push_back({(k == 3), d[8*k +: 8]});
        end
    endtask

    // Scoreboard monitor: every output handshake pops and compares one entry.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && out_ready) begin
            tests_run++;
            if (exp_a_q.size() == 0) begin
                tests_failed++;
                $display("FAIL a_unexpected_octet: got last=%0b data=%02h, required no output", a_out_last, a_out_data);
            end else begin
                ea = exp_a_q.pop_front();
                if ({a_out_last, a_out_data} !== ea) begin
                    tests_failed++;
                    $display("FAIL a_octet: got last=%0b data=%02h, required last=%0b data=%02h", a_out_last, a_out_data, ea[8], ea[7:0]);
                end
            end
        end
        if (rst_n && b_out_valid && out_ready) begin
            tests_run++;
            if (exp_b_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b_unexpected_octet: got last=%0b data=%02h, required no output", b_out_last, b_out_data);
            end else begin
                eb = exp_b_q.pop_front();
                if ({b_out_last, b_out_data} !== eb) begin
                    tests_failed++;
                    $display("FAIL b_octet: got last=%0b data=%02h, required last=%0b data=%02h", b_out_last, b_out_data, eb[8], eb[7:0]);
                end
            end
        end
    end

    // Driver: reset both DUTs and drop anything still expected.
    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        exp_a_q.delete();
        exp_b_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Driver: stream msg_buf[0..len-1]; stalls counts cycles in_ready was low.
    task automatic send_msg(input int len, input bit with_last, output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = msg_buf[i];
            in_last  = with_last && (i == len - 1);
            guard    = 0;
            @(negedge clk);
            while (!a_in_ready && guard < 200) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            if (guard >= 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", a_in_ready, guard);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Driver: wait until both scoreboards drain and both DUTs go idle.
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || a_busy || b_busy) && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        tests_run++;
        if (guard >= 300) begin
            tests_failed++;
            $display("FAIL idle_timeout: pending a=%0d b=%0d busy=%0b, required 0 0 0", exp_a_q.size(), exp_b_q.size(), a_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({a_in_ready, a_out_valid, a_out_last, a_busy, b_in_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got rdy=%0b vld=%0b last=%0b busy=%0b brdy=%0b, required all 0",
                     a_in_ready, a_out_valid, a_out_last, a_busy, b_in_ready);
        end
        tests_run++;
        if (a_out_data !== 8'h00 || a_msg_count !== 8'h00 || b_msg_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got data=%02h cnt=%0d bcnt=%0d, required 0 0 0", a_out_data, a_msg_count, b_msg_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_in_ready !== 1'b1 || a_dbg_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%0b state=%0b, required 1 0", a_in_ready, a_dbg_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_a();
        int s;
        apply_reset();
        out_ready  = 1'b1;
        msg_buf[0] = 8'h61;
        push_expected(32'hE40C292C);
        send_msg(1, 1'b1, s);
        wait_idle();
        tests_run++;
        if (a_msg_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_a_count: got %0d, required 1", a_msg_count);
        end
    endtask

    task automatic test_foobar();
        int s;
        apply_reset();
        out_ready = 1'b1;
        msg_buf[0] = 8'h66; msg_buf[1] = 8'h6f; msg_buf[2] = 8'h6f;
        msg_buf[3] = 8'h62; msg_buf[4] = 8'h61; msg_buf[5] = 8'h72;
        push_expected(32'hBF9CF968);
        send_msg(6, 1'b1, s);
        tests_run++;
        if (s !== 0) begin
            tests_failed++;
            $display("FAIL foobar_stalls: got %0d stall cycles, required 0", s);
        end
        @(negedge clk);
        tests_run++;
        if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL foobar_latency: got out_valid a=%0b b=%0b, required 1 1", a_out_valid, b_out_valid);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int s;
        apply_reset();
        out_ready  = 1'b1;
        msg_buf[0] = 8'h61;
        push_expected(32'hE40C292C);
        send_msg(1, 1'b1, s);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (a_out_data !== 8'h0C || a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || b_out_data !== 8'h29) begin
                tests_failed++;
                $display("FAIL backpressure_hold: got a=%02h vld=%0b rdy=%0b b=%02h, required 0c 1 0 29",
                         a_out_data, a_out_valid, a_in_ready, b_out_data);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        tests_run++;
        if (a_msg_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL backpressure_count: got %0d, required 1", a_msg_count);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        apply_reset();
        out_ready  = 1'b1;
        msg_buf[0] = 8'h61;
        push_expected(32'hE40C292C);
        send_msg(1, 1'b1, s);
        msg_buf[0] = 8'h66; msg_buf[1] = 8'h6f; msg_buf[2] = 8'h6f;
        msg_buf[3] = 8'h62; msg_buf[4] = 8'h61; msg_buf[5] = 8'h72;
        push_expected(32'hBF9CF968);
        send_msg(6, 1'b1, s);
        wait_idle();
        tests_run++;
        if (a_msg_count !== 8'd2 || b_msg_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL back_to_back_count: got a=%0d b=%0d, required 2 2", a_msg_count, b_msg_count);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        apply_reset();
        out_ready  = 1'b1;
        msg_buf[0] = 8'h61;
        push_expected(32'hE40C292C);
        send_msg(1, 1'b1, s);
        wait_idle();
        msg_buf[0] = 8'h66; msg_buf[1] = 8'h6f; msg_buf[2] = 8'h6f;
        send_msg(3, 1'b0, s);
        @(negedge clk);
        tests_run++;
        if (a_busy !== 1'b1 || a_msg_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL mid_msg_busy: got busy=%0b cnt=%0d, required 1 1", a_busy, a_msg_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_msg_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_msg_reset: got busy=%0b vld=%0b cnt=%0d, required 0 0 0", a_busy, a_out_valid, a_msg_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Reset while a digest is waiting on a stalled consumer.
        out_ready  = 1'b0;
        msg_buf[0] = 8'h5A;
        send_msg(1, 1'b1, s);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_emit_reset: got vld a=%0b b=%0b busy=%0b, required 0 0 0", a_out_valid, b_out_valid, a_busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready  = 1'b1;
        msg_buf[0] = 8'h61;
        push_expected(32'hE40C292C);
        send_msg(1, 1'b1, s);
        wait_idle();
        tests_run++;
        if (a_msg_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL after_reset_count: got %0d, required 1", a_msg_count);
        end
    endtask

    task automatic test_count_wrap();
        int s;
        int len;
        logic [1:0] ec;
        apply_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) msg_buf[i] = 8'($urandom_range(0, 255));
            push_expected(fnv_model(len));
            send_msg(len, 1'b1, s);
            wait_idle();
            ec = k[1:0];
            tests_run++;
            if (b_msg_count !== ec || a_msg_count !== k[7:0]) begin
                tests_failed++;
                $display("FAIL count_wrap: got b=%0d a=%0d, required b=%0d a=%0d", b_msg_count, a_msg_count, ec, k);
            end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_single_a();
        test_foobar();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL watchdog: simulation exceeded time limit, %0d failed so far", tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
